// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input operand selector with a registered valid/ready output,
// a 2-entry skid buffer for downstream stalls, a synchronous flush, and
// illegal-selector detection that drives zero data plus a saturating error count.
module mux_n_pipe #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned N_ENTRADAS  = 4,
   parameter int unsigned MAPA_LEGADO = 0,
   localparam int unsigned SEL_W      = (N_ENTRADAS > 2) ? $clog2(N_ENTRADAS) : 1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [SEL_W-1:0]            seletor,
   input  logic [N_ENTRADAS*WIDTH-1:0] entradas,
   input  logic                        valid_in,
   output logic                        ready_out,
   input  logic                        flush,
   output logic [WIDTH-1:0]            saida,
   output logic                        valid_out,
   input  logic                        ready_in,
   output logic                        erro_sel,
   output logic [15:0]                 cont_erros
);

   // The legacy map only exists for the 3-input build: codes 01 and 10 are swapped.
   localparam bit LEGADO3 = (MAPA_LEGADO != 0) && (N_ENTRADAS == 3);

   typedef enum logic [1:0] {
      VAZIO = 2'd0,
      UM    = 2'd1,
      CHEIO = 2'd2
   } estado_t;

   estado_t           estado_q, estado_d;
   logic [WIDTH-1:0]  saida_q, saida_d;
   logic              erro_q, erro_d;
   logic [WIDTH-1:0]  skid_dado_q, skid_dado_d;
   logic              skid_erro_q, skid_erro_d;
   logic              ready_q, ready_d;
   logic [15:0]       cont_q, cont_d;

   logic [WIDTH-1:0]  sel_dado;
   logic              sel_erro;
   logic [31:0]       idx_bruto;
   logic [31:0]       idx;
   logic              aceita;
   logic              transf;

   // Decode the selector into an input index and pick that word (zero if illegal).
   always_comb begin
      sel_dado  = '0;
      sel_erro  = 1'b1;
      idx_bruto = 32'(seletor);
      idx       = idx_bruto;
      if (LEGADO3) begin
         if (idx_bruto == 32'd1) begin
            idx = 32'd2;
         end else if (idx_bruto == 32'd2) begin
            idx = 32'd1;
         end
      end
      for (int unsigned k = 0; k < N_ENTRADAS; k++) begin
         if (idx == k) begin
            sel_dado = entradas[k*WIDTH +: WIDTH];
            sel_erro = 1'b0;
         end
      end
   end

   // Occupancy state machine: output register first, skid second, strict FIFO order.
   always_comb begin
      estado_d    = estado_q;
      saida_d     = saida_q;
      erro_d      = erro_q;
      skid_dado_d = skid_dado_q;
      skid_erro_d = skid_erro_q;
      cont_d      = cont_q;
      aceita      = valid_in && ready_q;
      transf      = (estado_q != VAZIO) && ready_in;

      if (flush) begin
         // Flush drops any offered beat uncounted; saida data is left untouched.
         estado_d    = VAZIO;
         erro_d      = 1'b0;
         skid_erro_d = 1'b0;
      end else begin
         if (aceita && sel_erro && (cont_q != '1)) begin
            cont_d = cont_q + 16'd1;
         end
         case (estado_q)
            VAZIO: begin
               if (aceita) begin
                  saida_d  = sel_dado;
                  erro_d   = sel_erro;
                  estado_d = UM;
               end
            end
            UM: begin
               if (aceita && transf) begin
                  saida_d = sel_dado;
                  erro_d  = sel_erro;
               end else if (aceita) begin
                  skid_dado_d = sel_dado;
                  skid_erro_d = sel_erro;
                  estado_d    = CHEIO;
               end else if (transf) begin
                  erro_d   = 1'b0;
                  estado_d = VAZIO;
               end
            end
            CHEIO: begin
               if (transf) begin
                  saida_d  = skid_dado_q;
                  erro_d   = skid_erro_q;
                  estado_d = UM;
               end
            end
            default: begin
               erro_d   = 1'b0;
               estado_d = VAZIO;
            end
         endcase
      end

      // ready_out is a flop, so it is computed from the next state rather than ready_in.
      ready_d = (estado_d != CHEIO);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         estado_q    <= VAZIO;
         saida_q     <= '0;
         erro_q      <= 1'b0;
         skid_dado_q <= '0;
         skid_erro_q <= 1'b0;
         ready_q     <= 1'b1;
         cont_q      <= '0;
      end else begin
         estado_q    <= estado_d;
         saida_q     <= saida_d;
         erro_q      <= erro_d;
         skid_dado_q <= skid_dado_d;
         skid_erro_q <= skid_erro_d;
         ready_q     <= ready_d;
         cont_q      <= cont_d;
      end
   end

   assign saida      = saida_q;
   assign valid_out  = (estado_q != VAZIO);
   assign ready_out  = ready_q;
   assign erro_sel   = erro_q;
   assign cont_erros = cont_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: directed bench for mux_n_pipe covering a 4-input instance
// (streaming, backpressure, flush, reset) and two 3-input instances
// (illegal selector with saturation, legacy selector map).
module tb_mux_n_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Instance 0: N=4, WIDTH=32
   logic         rst0, vin0, rdy_o0, flush0, vout0, rin0, err0;
   logic [1:0]   sel0;
   logic [127:0] ent0;
   logic [31:0]  saida0;
   logic [15:0]  cont0;

   // Instances 1 and 2: N=3, MAPA_LEGADO 0 and 1
   logic         rst12, rin12;
   logic [95:0]  ent12;
   logic [1:0]   sel1, sel2;
   logic         vin1, rdy_o1, flush1, vout1, err1;
   logic         vin2, rdy_o2, flush2, vout2, err2;
   logic [31:0]  saida1, saida2;
   logic [15:0]  cont1, cont2;

   mux_n_pipe #(.WIDTH(32), .N_ENTRADAS(4), .MAPA_LEGADO(0)) u0 (
      .clk(clk), .reset_n(rst0), .seletor(sel0), .entradas(ent0),
      .valid_in(vin0), .ready_out(rdy_o0), .flush(flush0), .saida(saida0),
      .valid_out(vout0), .ready_in(rin0), .erro_sel(err0), .cont_erros(cont0)
   );

   mux_n_pipe #(.WIDTH(32), .N_ENTRADAS(3), .MAPA_LEGADO(0)) u1 (
      .clk(clk), .reset_n(rst12), .seletor(sel1), .entradas(ent12),
      .valid_in(vin1), .ready_out(rdy_o1), .flush(flush1), .saida(saida1),
      .valid_out(vout1), .ready_in(rin12), .erro_sel(err1), .cont_erros(cont1)
   );

   mux_n_pipe #(.WIDTH(32), .N_ENTRADAS(3), .MAPA_LEGADO(1)) u2 (
      .clk(clk), .reset_n(rst12), .seletor(sel2), .entradas(ent12),
      .valid_in(vin2), .ready_out(rdy_o2), .flush(flush2), .saida(saida2),
      .valid_out(vout2), .ready_in(rin12), .erro_sel(err2), .cont_erros(cont2)
   );

   // Scoreboard for instance 0: {err, data} pushed on accept, popped on transfer.
   logic [32:0] sb[$];

   always @(posedge clk) begin
      logic [32:0] e;
      if (!rst0 || flush0) begin
         sb.delete();
      end else begin
         if (vout0 && rin0) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_beat", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("sb_data", saida0, e[31:0]);
               check("sb_err", {31'd0, err0}, {31'd0, e[32]});
            end
         end
         if (vin0 && rdy_o0) begin
            sb.push_back({1'b0, ent0[sel0*32 +: 32]});
         end
      end
   end

   initial begin
      rst0 = 1'b0; vin0 = 1'b0; flush0 = 1'b0; rin0 = 1'b0; sel0 = '0;
      ent0 = {32'h44, 32'h33, 32'h22, 32'h11};
      rst12 = 1'b0; rin12 = 1'b1; ent12 = {32'hC, 32'hB, 32'hA};
      vin1 = 1'b0; flush1 = 1'b0; sel1 = '0;
      vin2 = 1'b0; flush2 = 1'b0; sel2 = '0;
      tick();
      tick();

      // Reset values
      check("rst_saida", saida0, 32'h0);
      check("rst_valid", {31'd0, vout0}, 32'd0);
      check("rst_erro", {31'd0, err0}, 32'd0);
      check("rst_cont", {16'd0, cont0}, 32'd0);
      check("rst_ready", {31'd0, rdy_o0}, 32'd1);
      check("rst_ready_u1", {31'd0, rdy_o1}, 32'd1);
      check("rst_ready_u2", {31'd0, rdy_o2}, 32'd1);
      check("rst_cont_u1", {16'd0, cont1}, 32'd0);
      rst0 = 1'b1;
      rst12 = 1'b1;

      // Streaming with ready_in=1: one-cycle latency, ready_out stays high
      rin0 = 1'b1;
      for (int s = 0; s < 4; s++) begin
         vin0 = 1'b1;
         sel0 = 2'(s);
         tick();
         check("stream_valid", {31'd0, vout0}, 32'd1);
         check("stream_ready", {31'd0, rdy_o0}, 32'd1);
         check("stream_data", saida0, 32'h11 * (s + 1));
      end
      vin0 = 1'b0;
      tick();
      check("stream_drain_valid", {31'd0, vout0}, 32'd0);

      // Backpressure: A(sel0) then B(sel1) fill to CHEIO, a third offer is refused
      rin0 = 1'b0; vin0 = 1'b1; sel0 = 2'd0;
      tick();
      check("bp_a_valid", {31'd0, vout0}, 32'd1);
      check("bp_a_ready", {31'd0, rdy_o0}, 32'd1);
      check("bp_a_data", saida0, 32'h11);
      sel0 = 2'd1;
      tick();
      check("bp_full_ready", {31'd0, rdy_o0}, 32'd0);
      check("bp_full_data", saida0, 32'h11);
      sel0 = 2'd2;
      tick();
      check("bp_hold_ready", {31'd0, rdy_o0}, 32'd0);
      check("bp_hold_data", saida0, 32'h11);
      vin0 = 1'b0; rin0 = 1'b1;
      tick();
      check("bp_b_data", saida0, 32'h22);
      check("bp_b_valid", {31'd0, vout0}, 32'd1);
      check("bp_ready_back", {31'd0, rdy_o0}, 32'd1);
      tick();
      check("bp_drain_valid", {31'd0, vout0}, 32'd0);

      // Flush while CHEIO with a beat offered
      rin0 = 1'b0; vin0 = 1'b1; sel0 = 2'd3;
      tick();
      sel0 = 2'd0;
      tick();
      check("fl_full_ready", {31'd0, rdy_o0}, 32'd0);
      flush0 = 1'b1; sel0 = 2'd2;
      tick();
      check("fl_valid", {31'd0, vout0}, 32'd0);
      check("fl_ready", {31'd0, rdy_o0}, 32'd1);
      check("fl_erro", {31'd0, err0}, 32'd0);
      check("fl_saida_hold", saida0, 32'h44);
      check("fl_cont", {16'd0, cont0}, 32'd0);
      flush0 = 1'b0; vin0 = 1'b0; rin0 = 1'b1;
      tick();
      check("fl_no_emit", {31'd0, vout0}, 32'd0);

      // Flush in UM with a beat offered while ready_out=1
      rin0 = 1'b0; vin0 = 1'b1; sel0 = 2'd1;
      tick();
      flush0 = 1'b1; sel0 = 2'd3;
      tick();
      check("flum_valid", {31'd0, vout0}, 32'd0);
      check("flum_ready", {31'd0, rdy_o0}, 32'd1);
      flush0 = 1'b0; vin0 = 1'b0;
      tick();
      check("flum_no_emit", {31'd0, vout0}, 32'd0);

      // Reset in CHEIO together with flush
      rin0 = 1'b0; vin0 = 1'b1; sel0 = 2'd1;
      tick();
      sel0 = 2'd2;
      tick();
      check("rm_full_ready", {31'd0, rdy_o0}, 32'd0);
      flush0 = 1'b1; rst0 = 1'b0;
      tick();
      check("rm_saida", saida0, 32'h0);
      check("rm_valid", {31'd0, vout0}, 32'd0);
      check("rm_erro", {31'd0, err0}, 32'd0);
      check("rm_cont", {16'd0, cont0}, 32'd0);
      check("rm_ready", {31'd0, rdy_o0}, 32'd1);
      rst0 = 1'b1; flush0 = 1'b0; vin0 = 1'b0;
      tick();
      check("sb_empty", sb.size(), 32'd0);

      // Legacy map, N=3: 00->A, 10->B, 01->C, 11 illegal
      vin2 = 1'b1; sel2 = 2'b00;
      tick();
      check("leg_00", saida2, 32'hA);
      check("leg_00_err", {31'd0, err2}, 32'd0);
      sel2 = 2'b10;
      tick();
      check("leg_10", saida2, 32'hB);
      sel2 = 2'b01;
      tick();
      check("leg_01", saida2, 32'hC);
      check("leg_01_err", {31'd0, err2}, 32'd0);
      sel2 = 2'b11;
      tick();
      check("leg_11", saida2, 32'h0);
      check("leg_11_err", {31'd0, err2}, 32'd1);
      check("leg_11_valid", {31'd0, vout2}, 32'd1);
      check("leg_cont", {16'd0, cont2}, 32'd1);
      vin2 = 1'b0;
      tick();

      // Illegal selector, N=3, plain map
      vin1 = 1'b1; sel1 = 2'b11;
      tick();
      check("ill_valid", {31'd0, vout1}, 32'd1);
      check("ill_data", saida1, 32'h0);
      check("ill_err", {31'd0, err1}, 32'd1);
      check("ill_cont", {16'd0, cont1}, 32'd1);
      sel1 = 2'b00;
      tick();
      check("ill_next_data", saida1, 32'hA);
      check("ill_next_err", {31'd0, err1}, 32'd0);
      check("ill_next_cont", {16'd0, cont1}, 32'd1);
      vin1 = 1'b0;
      tick();

      // Flushed illegal offer is not counted
      flush1 = 1'b1; vin1 = 1'b1; sel1 = 2'b11;
      tick();
      check("ill_fl_valid", {31'd0, vout1}, 32'd0);
      check("ill_fl_cont", {16'd0, cont1}, 32'd1);
      flush1 = 1'b0; vin1 = 1'b0;
      tick();
      check("ill_fl_no_emit", {31'd0, vout1}, 32'd0);
      check("ill_fl_cont2", {16'd0, cont1}, 32'd1);

      // Saturation: 65534 more illegal beats reach 0xFFFF, one more stays there
      vin1 = 1'b1; sel1 = 2'b11;
      repeat (65534) tick();
      check("sat_reach", {16'd0, cont1}, 32'hFFFF);
      tick();
      check("sat_hold", {16'd0, cont1}, 32'hFFFF);
      check("sat_err", {31'd0, err1}, 32'd1);
      check("sat_data", saida1, 32'h0);
      vin1 = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-input operand selector with a registered, flow-controlled output for the pipelined datapath (forwarding/writeback selection).
- Selects one of N_ENTRADAS words per beat and registers the result with a valid/ready handshake.
- A 2-entry skid buffer absorbs downstream stalls. A per-stage flush is provided.
- An illegal selector produces zero data, an aligned error flag and a saturating error count, instead of undefined data.

Parameters:
- WIDTH, 32: data width per input.
- N_ENTRADAS, 4: number of inputs, 2..16. Selector width SEL_W = clog2(N_ENTRADAS), minimum 1.
- MAPA_LEGADO, 0: when 1 and N_ENTRADAS==3, selector 2'b10 picks input 1 and 2'b01 picks input 2. Otherwise, and when 0, selector value k picks input k.

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- seletor, input, SEL_W: input index, sampled with the beat.
- entradas, input, N_ENTRADAS*WIDTH: input k occupies bits [k*WIDTH +: WIDTH].
- valid_in, input, 1: upstream beat valid.
- ready_out, output, 1: block can accept a beat.
- flush, input, 1: synchronous pipeline flush.
- saida, output, WIDTH: selected, registered data.
- valid_out, output, 1: saida valid.
- ready_in, input, 1: downstream accepts.
- erro_sel, output, 1: current saida beat came from an illegal selector.
- cont_erros, output, 16: saturating count of accepted illegal beats.

Behaviour:
- Reset (reset_n=0 at a rising edge): saida=0, valid_out=0, erro_sel=0, cont_erros=0, skid empty, ready_out=1. Reset dominates flush and all other inputs.
- Accept: valid_in && ready_out at a rising edge. Output: transfer when valid_out && ready_in at a rising edge.
- ready_out is registered and equals !skid_valid. It does not depend combinationally on ready_in.
- Selection is evaluated at accept time.
  - If seletor >= N_ENTRADAS, the stored data is 0 and the beat's error bit is 1.
  - With MAPA_LEGADO=1 and N=3, selector 2'b11 is illegal.
- Latency: a beat accepted at edge t appears on saida/valid_out after edge t, i.e. 1 cycle, when the output register is free.
- States, determined by occupancy:
  - VAZIO: valid_out=0, skid empty.
  - UM: valid_out=1, skid empty.
  - CHEIO: valid_out=1, skid full, ready_out=0.
- Transitions:
  - VAZIO + accept -> UM. The beat goes to the output register.
  - UM + accept + transfer -> UM. The new beat replaces the output register.
  - UM + accept + no transfer -> CHEIO. The beat goes to skid.
  - UM + transfer + no accept -> VAZIO.
  - CHEIO + transfer -> UM. Skid moves to the output register. No accept is possible because ready_out=0.
  - CHEIO + no transfer -> hold.
- Ordering is strict FIFO. The skid beat always leaves before any later beat.
- erro_sel travels with its beat through the skid and the output register, aligned with saida.
- cont_erros:
  - Increments by 1 on each accepted illegal beat and saturates at 16'hFFFF.
  - Counts at accept time, even if the beat is later flushed.
  - Not cleared by flush.
- flush=1 at an edge:
  - Clears valid_out, skid and erro_sel. Next state is VAZIO and ready_out=1 next cycle.
  - A beat offered in the same cycle is discarded and not counted, even if ready_out=1.
  - saida data holds its last value; only valid is cleared.
  - Flush overrides a simultaneous transfer. The downstream must treat that beat as not delivered.
- When valid_out=0, saida holds its last value. Its content is don't-care for the consumer.
- Data held at valid_out=1 && ready_in=0 is stable until transferred. The same holds for erro_sel.
- No combinational path from entradas or seletor to saida.

Test Plan:
- Reset then streaming: N=4, WIDTH=32, entradas={0x44,0x33,0x22,0x11} for inputs 3..0, ready_in=1, seletor 0,1,2,3 on consecutive cycles -> saida 0x11,0x22,0x33,0x44 one cycle after each accept; valid_out high 4 cycles; ready_out stays 1.
- Backpressure: ready_in=0, push beats A(sel0) and B(sel1) -> after 2 accepts ready_out=0 (CHEIO), saida=A held. Raise ready_in -> A then B out in order, ready_out=1 one cycle after A transfers.
- Illegal select: N=3, MAPA_LEGADO=0, seletor=2'b11 -> saida=0, erro_sel=1, cont_erros=1. Next legal beat -> erro_sel=0. Preload cont_erros to 0xFFFF by 65535 illegal beats, one more -> stays 0xFFFF.
- Legacy map: N=3, MAPA_LEGADO=1, inputs 0..2 = 0xA,0xB,0xC -> seletor 00->0xA, 10->0xB, 01->0xC, 11->0 with erro_sel=1.
- Flush in CHEIO with valid_in=1 -> next cycle valid_out=0, ready_out=1. The offered beat is never emitted and cont_erros is unchanged.
- Reset mid-operation: CHEIO with flush=1 and reset_n=0 -> all outputs at reset values after that edge.
